mem_channel_arbiter: RTL
========================

MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 8, cache miss/writeback ports served.
REQ-004 SHALL have parameter NUM_CHANNELS, default 2, concurrent memory channels (1..NUM_CONSUMERS).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low; state clears immediately while low.
REQ-007 SHALL have ports consumer_read_valid / consumer_read_ready  in / out  NUM_CONSUMERS  per-consumer read request / completion.
REQ-008 SHALL have ports consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  and consumer_read_data  out  DATA_BITS x NUM_CONSUMERS.
REQ-009 SHALL have ports consumer_write_valid / consumer_write_ready  in / out  NUM_CONSUMERS  per-consumer writeback request / completion.
REQ-010 SHALL have ports consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  and consumer_write_data  in  DATA_BITS x NUM_CONSUMERS.
REQ-011 SHALL have ports mem_read_valid / mem_read_ready  out / in  NUM_CHANNELS, mem_read_address  out  ADDR_BITS x NUM_CHANNELS, mem_read_data  in  DATA_BITS x NUM_CHANNELS.
REQ-012 SHALL have ports mem_write_valid / mem_write_ready  out / in  NUM_CHANNELS, mem_write_address  out  ADDR_BITS x NUM_CHANNELS, mem_write_data  out  DATA_BITS x NUM_CHANNELS.

Function
REQ-013 Each channel SHALL run an independent FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
REQ-014 IDLE: channel SHALL claim the lowest-index consumer with read or write valid that is neither owned by another channel nor claimed by a lower-index channel in the same cycle.
REQ-015 A consumer asserting both valids SHALL be served write first; read is claimed only after the write completes (eviction before fill).
REQ-016 On claim the channel SHALL register address (and write data), assert mem_read_valid or mem_write_valid next cycle, and enter READ_WAITING or WRITE_WAITING.
REQ-017 WAITING: mem valid/address/data SHALL hold stable until the matching mem ready is sampled high; mem ready while valid low SHALL be ignored.
REQ-018 On mem_read_ready: capture mem_read_data into consumer_read_data, drop mem_read_valid, assert consumer_read_ready next cycle, enter READ_RELAYING.
REQ-019 On mem_write_ready: drop mem_write_valid, assert consumer_write_ready next cycle, enter WRITE_RELAYING.
REQ-020 RELAYING: consumer ready and read data SHALL hold until the consumer's corresponding valid is sampled low; then ready drops, ownership releases, state returns to IDLE.
REQ-021 Latency: consumer valid at edge t -> mem valid high after edge t+1 (min); mem ready at edge m -> consumer ready high after edge m+1.
REQ-022 A released consumer SHALL NOT be re-claimed in the same cycle it is released; a new claim is possible the following cycle.
REQ-023 Consumer valid dropping during WAITING SHALL NOT abort the memory transaction; on completion RELAYING sees valid low and releases after one ready cycle.
REQ-024 Requests exceeding free channels SHALL wait, unclaimed, with no loss; each consumer is owned by at most one channel at any time.
REQ-025 Unowned consumer ready outputs SHALL be 0; mem outputs of IDLE channels SHALL be 0.

Reset
REQ-026 While reset low: all FSMs IDLE, all ownership cleared, every output (ready, read data, mem valids, addresses, write data) 0.
REQ-027 Reset mid-transaction SHALL abandon it silently; after release no transaction is replayed unless the consumer still asserts valid.

Verification
REQ-028 Single read: consumer 3 read addr 0x42, mem ready 3 cycles later with data 0xA5 -> channel 0 drives 0x42, consumer_read_data[3]=0xA5 with ready held until valid drops.
REQ-029 Contention: consumers 1,4,6 read same cycle, NUM_CHANNELS=2 -> channel 0 takes 1, channel 1 takes 4, consumer 6 claimed only after a channel returns IDLE.
REQ-030 Eviction then fill: consumer 2 asserts write 0x10/0x77 and read 0x30 -> mem write 0x10/0x77 completes first, then mem read 0x30.
REQ-031 Spurious ready: mem_read_ready high while channel IDLE -> no state change, no consumer ready.
REQ-032 Reset asserted during READ_WAITING -> mem_read_valid and all outputs 0 immediately (asynchronous), FSM IDLE after release.

Source files
------------

// File: rtl/mem_channel_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_channel_arbiter_if
// Bundles the consumer-side (cache miss / writeback) request ports and the
// memory-side channel ports of mem_channel_arbiter.
//
//   consumer_read_*   : per-consumer read request, address, completion, data
//   consumer_write_*  : per-consumer writeback request, address, data, completion
//   mem_read_*        : per-channel memory read request / response
//   mem_write_*       : per-channel memory write request / response
//
// Modports:
//   slave  : the arbiter's view (takes consumer requests, drives memory)
//   master : the environment's view (consumers + memory model)
// ---------------------------------------------------------------------------
interface mem_channel_arbiter_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
);

  // Consumer side
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;

  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;

  // Memory side
  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;

  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;

  modport slave (
    input  consumer_read_valid,
    input  consumer_read_address,
    output consumer_read_ready,
    output consumer_read_data,
    input  consumer_write_valid,
    input  consumer_write_address,
    input  consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data,
    output mem_write_valid,
    output mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport master (
    output consumer_read_valid,
    output consumer_read_address,
    input  consumer_read_ready,
    input  consumer_read_data,
    output consumer_write_valid,
    output consumer_write_address,
    output consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data,
    input  mem_write_valid,
    input  mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/mem_channel_arbiter.sv
// ---------------------------------------------------------------------------
// mem_channel_arbiter
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS cache ports.
// Every channel runs its own FSM: it claims the lowest-index free consumer
// with a pending request, issues one memory transaction, relays the
// completion back to the consumer and releases it once the consumer drops
// its valid. A consumer with both a writeback and a read pending is served
// write first (eviction before fill).
//
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : asynchronous, active-low
//   bus   : mem_channel_arbiter_if.slave (consumer and memory handshakes)
// ---------------------------------------------------------------------------
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input logic                   clk,
  input logic                   reset,
  mem_channel_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_READ_RELAYING,
    S_WRITE_RELAYING
  } state_e;

  // Control state (reset)
  state_e                 state_q [NUM_CHANNELS];
  state_e                 state_d [NUM_CHANNELS];
  logic [IDX_W-1:0]       owner_q [NUM_CHANNELS];
  logic [IDX_W-1:0]       owner_d [NUM_CHANNELS];

  // Datapath holding registers (no reset; every output is gated by state)
  logic [ADDR_BITS-1:0]   addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]   addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]   wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]   wdata_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0]   rdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]   rdata_d [NUM_CHANNELS];

  // Arbitration helpers
  logic [NUM_CONSUMERS-1:0] owned;
  logic [NUM_CONSUMERS-1:0] taken;
  logic                     claimed;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= S_IDLE;
        owner_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        owner_q[ch] <= owner_d[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      addr_q[ch]  <= addr_d[ch];
      wdata_q[ch] <= wdata_d[ch];
      rdata_q[ch] <= rdata_d[ch];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: claim arbitration and per-channel transitions
  // -------------------------------------------------------------------------
  always_comb begin
    owned   = '0;
    taken   = '0;
    claimed = 1'b0;

    // A consumer counts as owned for the whole time a channel is out of IDLE,
    // including the cycle it is being released. That also keeps a released
    // consumer from being re-claimed on the same edge.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state_q[ch] != S_IDLE) owned[owner_q[ch]] = 1'b1;
    end

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      owner_d[ch] = owner_q[ch];
      addr_d[ch]  = addr_q[ch];
      wdata_d[ch] = wdata_q[ch];
      rdata_d[ch] = rdata_q[ch];
      claimed     = 1'b0;

      unique case (state_q[ch])
        S_IDLE: begin
          // Lower-index channels have already marked their picks in 'taken'
          for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (!claimed && !owned[c] && !taken[c] &&
                (bus.consumer_read_valid[c] || bus.consumer_write_valid[c])) begin
              claimed     = 1'b1;
              taken[c]    = 1'b1;
              owner_d[ch] = IDX_W'(c);
              if (bus.consumer_write_valid[c]) begin
                state_d[ch] = S_WRITE_WAITING;
                addr_d[ch]  = bus.consumer_write_address[c];
                wdata_d[ch] = bus.consumer_write_data[c];
              end else begin
                state_d[ch] = S_READ_WAITING;
                addr_d[ch]  = bus.consumer_read_address[c];
              end
            end
          end
        end

        S_READ_WAITING: begin
          if (bus.mem_read_ready[ch]) begin
            rdata_d[ch] = bus.mem_read_data[ch];
            state_d[ch] = S_READ_RELAYING;
          end
        end

        S_WRITE_WAITING: begin
          if (bus.mem_write_ready[ch]) state_d[ch] = S_WRITE_RELAYING;
        end

        S_READ_RELAYING: begin
          if (!bus.consumer_read_valid[owner_q[ch]]) state_d[ch] = S_IDLE;
        end

        S_WRITE_RELAYING: begin
          if (!bus.consumer_write_valid[owner_q[ch]]) state_d[ch] = S_IDLE;
        end

        default: state_d[ch] = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // -------------------------------------------------------------------------
  always_comb begin
    bus.consumer_read_ready  = '0;
    bus.consumer_read_data   = '0;
    bus.consumer_write_ready = '0;
    bus.mem_read_valid       = '0;
    bus.mem_read_address     = '0;
    bus.mem_write_valid      = '0;
    bus.mem_write_address    = '0;
    bus.mem_write_data       = '0;

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      unique case (state_q[ch])
        S_READ_WAITING: begin
          bus.mem_read_valid[ch]   = 1'b1;
          bus.mem_read_address[ch] = addr_q[ch];
        end
        S_WRITE_WAITING: begin
          bus.mem_write_valid[ch]   = 1'b1;
          bus.mem_write_address[ch] = addr_q[ch];
          bus.mem_write_data[ch]    = wdata_q[ch];
        end
        S_READ_RELAYING: begin
          bus.consumer_read_ready[owner_q[ch]] = 1'b1;
          bus.consumer_read_data[owner_q[ch]]  = rdata_q[ch];
        end
        S_WRITE_RELAYING: begin
          bus.consumer_write_ready[owner_q[ch]] = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
